// File: rtl/johnson_decoder_pkg.sv
// Shared types and combinational helpers for the Johnson-code decoder.
// The helpers take the code width as an argument so one package serves
// every instance width up to JC_MAX_W bits.
package johnson_decoder_pkg;

    localparam int JC_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } jd_state_t;

    // A legal Johnson word has at most one 0/1 boundary between adjacent
    // bits: all-zeros, all-ones, a run of ones from bit0, or a run of ones
    // ending at the MSB.
    function automatic logic jc_is_legal(input logic [JC_MAX_W-1:0] w, input int n);
        int edges;
        edges = 0;
        for (int i = 0; i < JC_MAX_W - 1; i++) begin
            if ((i < n - 1) && (w[i] != w[i+1]))
                edges++;
        end
        return (edges <= 1);
    endfunction

    // Position in the 2n-long cycle: the filling half (MSB=0) counts ones,
    // the draining half (MSB=1) counts down from 2n.
    function automatic int jc_index(input logic [JC_MAX_W-1:0] w, input int n);
        int   pop;
        logic msb;
        pop = 0;
        msb = 1'b0;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if ((i < n) && w[i])
                pop++;
            if (i == n - 1)
                msb = w[i];
        end
        return msb ? (2 * n - pop) : pop;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Pure combinational legality check and index decode of one Johnson word.
module johnson_code_decode
    import johnson_decoder_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  jc,
    output logic          legal,
    output logic [IW-1:0] idx
);

    logic [JC_MAX_W-1:0] wide;

    // Zero-extend the word to the helper functions' fixed width.
    always_comb begin
        wide        = '0;
        wide[N-1:0] = jc;
    end

    assign legal = jc_is_legal(wide, N);
    assign idx   = IW'(jc_index(wide, N));

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code decoder with sequence tracking: decodes each sampled word to
// its cycle index, checks it against the expected successor, and runs a
// HUNT/CHECK/LOCKED acquisition FSM with an error-tolerant lock and a
// saturating wrap counter. Every output is registered (one-cycle latency).
module johnson_decoder
    import johnson_decoder_pkg::*;
#(
    parameter int N         = 4,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [N-1:0]              jc_in,
    output logic [$clog2(2*N)-1:0]    bin_out,
    output logic                      bin_valid,
    output logic                      illegal,
    output logic                      seq_err,
    output logic                      locked,
    output logic [7:0]                wrap_cnt
);

    localparam int IW = $clog2(2 * N);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);

    jd_state_t     state;
    logic [IW-1:0] ref_idx;
    logic [GW-1:0] good_cnt;
    logic [EW-1:0] err_cnt;

    logic          dec_legal;
    logic [IW-1:0] dec_idx;
    logic [IW-1:0] succ_idx;
    logic          is_succ;
    logic          is_wrap;

    johnson_code_decode #(
        .N  (N),
        .IW (IW)
    ) u_decode (
        .jc    (jc_in),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    // Expected next index wraps explicitly, since 2N need not be a power of two.
    always_comb begin
        succ_idx = (ref_idx == LAST_IDX) ? '0 : ref_idx + IW'(1);
        is_succ  = dec_legal && (dec_idx == succ_idx);
        is_wrap  = is_succ && (ref_idx == LAST_IDX);
    end

    // Acquisition FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HUNT;
            ref_idx   <= '0;
            good_cnt  <= '0;
            err_cnt   <= '0;
            wrap_cnt  <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            bin_valid <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            if (in_valid) begin
                // Output decode is independent of the FSM state.
                if (dec_legal) begin
                    bin_out   <= dec_idx;
                    bin_valid <= 1'b1;
                end else begin
                    illegal   <= 1'b1;
                end

                case (state)
                    ST_HUNT: begin
                        if (dec_legal) begin
                            ref_idx  <= dec_idx;
                            good_cnt <= '0;
                            state    <= ST_CHECK;
                        end
                    end

                    ST_CHECK: begin
                        if (!dec_legal) begin
                            state <= ST_HUNT;
                        end else if (is_succ) begin
                            ref_idx <= dec_idx;
                            if (good_cnt == GW'(LOCK_CNT - 1)) begin
                                state    <= ST_LOCKED;
                                locked   <= 1'b1;
                                good_cnt <= '0;
                                err_cnt  <= '0;
                            end else begin
                                good_cnt <= good_cnt + GW'(1);
                            end
                        end else begin
                            // Legal but out of order (a repeat included): restart here.
                            seq_err  <= 1'b1;
                            ref_idx  <= dec_idx;
                            good_cnt <= '0;
                        end
                    end

                    ST_LOCKED: begin
                        if (is_succ) begin
                            err_cnt <= '0;
                            ref_idx <= dec_idx;
                            if (is_wrap && (wrap_cnt != 8'hFF))
                                wrap_cnt <= wrap_cnt + 8'd1;
                        end else begin
                            // Illegal words keep the reference; legal wrong ones move it.
                            if (dec_legal) begin
                                seq_err <= 1'b1;
                                ref_idx <= dec_idx;
                            end
                            if (err_cnt == EW'(ERR_LIMIT - 1)) begin
                                state   <= ST_HUNT;
                                err_cnt <= '0;
                                locked  <= 1'b0;
                            end else begin
                                err_cnt <= err_cnt + EW'(1);
                            end
                        end
                    end

                    default: begin
                        state  <= ST_HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder (N=4): directed scenarios followed
// by randomized traffic, all compared against a table-driven reference model.
module tb_johnson_decoder;

    localparam int N         = 4;
    localparam int LOCK_CNT  = 2;
    localparam int ERR_LIMIT = 3;
    localparam int CYC       = 2 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] jc_in = '0;
    logic [2:0]   bin_out;
    logic         bin_valid;
    logic         illegal;
    logic         seq_err;
    logic         locked;
    logic [7:0]   wrap_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int codes[CYC];
    int m_mode, m_ref, m_good, m_err, m_wrap;
    int m_bo, m_bv, m_ill, m_se, m_lk;

    johnson_decoder #(
        .N         (N),
        .LOCK_CNT  (LOCK_CNT),
        .ERR_LIMIT (ERR_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .jc_in     (jc_in),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .illegal   (illegal),
        .seq_err   (seq_err),
        .locked    (locked),
        .wrap_cnt  (wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Position of w in the legal cycle, or -1 if w is not a legal word.
    function automatic int lookup(input int w);
        for (int k = 0; k < CYC; k++)
            if (codes[k] == w) return k;
        return -1;
    endfunction

    task automatic model(input logic r, input logic v, input int w);
        int k;
        if (r) begin
            m_mode = 0; m_ref = 0; m_good = 0; m_err = 0; m_wrap = 0;
            m_bo = 0; m_bv = 0; m_ill = 0; m_se = 0; m_lk = 0;
            return;
        end
        m_bv = 0; m_ill = 0; m_se = 0;
        if (!v) return;
        k = lookup(w);
        if (k >= 0) begin m_bo = k; m_bv = 1; end
        else m_ill = 1;
        case (m_mode)
            0: if (k >= 0) begin m_ref = k; m_good = 0; m_mode = 1; end
            1: begin
                if (k < 0) m_mode = 0;
                else if (k == (m_ref + 1) % CYC) begin
                    m_ref = k;
                    m_good++;
                    if (m_good >= LOCK_CNT) begin m_mode = 2; m_err = 0; m_good = 0; m_lk = 1; end
                end else begin
                    m_se = 1; m_ref = k; m_good = 0;
                end
            end
            default: begin
                if (k >= 0 && k == (m_ref + 1) % CYC) begin
                    m_err = 0;
                    if (m_ref == CYC - 1 && m_wrap < 255) m_wrap++;
                    m_ref = k;
                end else begin
                    if (k >= 0) begin m_se = 1; m_ref = k; end
                    m_err++;
                    if (m_err >= ERR_LIMIT) begin m_mode = 0; m_err = 0; m_lk = 0; end
                end
            end
        endcase
    endtask

    // Drive one cycle on the falling edge, then compare every output just after the rising edge.
    task automatic step(input logic r, input logic v, input int w);
        @(negedge clk);
        rst = r; in_valid = v; jc_in = N'(w);
        @(posedge clk);
        #1;
        model(r, v, w);
        chk("bin_out",   8'(bin_out),   8'(m_bo));
        chk("bin_valid", 8'(bin_valid), 8'(m_bv));
        chk("illegal",   8'(illegal),   8'(m_ill));
        chk("seq_err",   8'(seq_err),   8'(m_se));
        chk("locked",    8'(locked),    8'(m_lk));
        chk("wrap_cnt",  wrap_cnt,      8'(m_wrap));
    endtask

    initial begin
        int cur, r, w;
        // Legal cycle from the shift rule: next = (cur << 1) | ~MSB.
        codes[0] = 0;
        for (int k = 1; k < CYC; k++)
            codes[k] = ((codes[k-1] << 1) & ((1 << N) - 1)) | (((codes[k-1] >> (N - 1)) & 1) ^ 1);

        // Reset state
        step(1, 0, 0);
        chk("rst_locked", 8'(locked), 8'd0);
        chk("rst_wrap", wrap_cnt, 8'd0);

        // Lock acquisition: 0000,0001,0011
        step(0, 1, 4'b0000);
        chk("acq_bo0", 8'(bin_out), 8'd0);
        step(0, 1, 4'b0001);
        chk("acq_bo1", 8'(bin_out), 8'd1);
        chk("acq_notlocked", 8'(locked), 8'd0);
        step(0, 1, 4'b0011);
        chk("acq_bo2", 8'(bin_out), 8'd2);
        chk("acq_locked", 8'(locked), 8'd1);

        // Run to the wrap point: 1000 then 0000
        step(0, 1, 4'b0111);
        step(0, 1, 4'b1111);
        step(0, 1, 4'b1110);
        step(0, 1, 4'b1100);
        step(0, 1, 4'b1000);
        chk("wrap_before", wrap_cnt, 8'd0);
        step(0, 1, 4'b0000);
        chk("wrap_after", wrap_cnt, 8'd1);
        chk("wrap_noseq", 8'(seq_err), 8'd0);

        // Illegal word while locked
        step(0, 1, 4'b0101);
        chk("ill_pulse", 8'(illegal), 8'd1);
        chk("ill_hold", 8'(bin_out), 8'd0);
        chk("ill_nobv", 8'(bin_valid), 8'd0);
        chk("ill_locked", 8'(locked), 8'd1);

        // Sequence error while locked: ..0111 then 1100, then 1000 is fine
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0011);
        step(0, 1, 4'b0111);
        step(0, 1, 4'b1100);
        chk("seq_pulse", 8'(seq_err), 8'd1);
        chk("seq_bo", 8'(bin_out), 8'd6);
        step(0, 1, 4'b1000);
        chk("seq_recover", 8'(seq_err), 8'd0);

        // Idle cycles change nothing
        step(0, 0, 4'b0101);
        step(0, 0, 4'b0001);
        chk("idle_locked", 8'(locked), 8'd1);

        // Three consecutive errors drop lock; next legal word goes to CHECK
        step(0, 1, 4'b0101);
        step(0, 1, 4'b0101);
        chk("err2_locked", 8'(locked), 8'd1);
        step(0, 1, 4'b1011);
        chk("err3_unlocked", 8'(locked), 8'd0);
        step(0, 1, 4'b0011);
        chk("hunt_bv", 8'(bin_valid), 8'd1);
        chk("hunt_noseq", 8'(seq_err), 8'd0);
        step(0, 1, 4'b0111);
        step(0, 1, 4'b1111);
        chk("relock", 8'(locked), 8'd1);

        // Repeated code is a sequence error
        step(0, 1, 4'b1111);
        chk("repeat_seq", 8'(seq_err), 8'd1);

        // Reset while locked with wrap_cnt=5, in_valid high during reset
        step(1, 0, 0);
        for (int i = 0; i <= 5 * CYC; i++) step(0, 1, codes[i % CYC]);
        chk("wrap5", wrap_cnt, 8'd5);
        step(1, 1, codes[1]);
        chk("rst_wrap0", wrap_cnt, 8'd0);
        chk("rst_lk0", 8'(locked), 8'd0);
        chk("rst_bo0", 8'(bin_out), 8'd0);
        chk("rst_bv0", 8'(bin_valid), 8'd0);
        step(0, 1, codes[3]);
        chk("post_rst_bo", 8'(bin_out), 8'd3);
        chk("post_rst_noseq", 8'(seq_err), 8'd0);
        chk("post_rst_unlocked", 8'(locked), 8'd0);

        // Saturation of wrap_cnt, held across loss of lock
        step(1, 0, 0);
        for (int i = 0; i <= 258 * CYC; i++) step(0, 1, codes[i % CYC]);
        chk("wrap_sat", wrap_cnt, 8'd255);
        step(0, 1, 4'b0101);
        step(0, 1, 4'b0101);
        step(0, 1, 4'b0101);
        chk("sat_unlock", 8'(locked), 8'd0);
        chk("sat_hold", wrap_cnt, 8'd255);

        // Randomized traffic, mostly in-order with injected faults
        step(1, 0, 0);
        cur = 0;
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) step(1, ($urandom_range(0, 1) == 1), codes[cur]);
            else if (r < 10) step(0, 0, int'($urandom_range(0, 15)));
            else if (r < 75) begin cur = (cur + 1) % CYC; step(0, 1, codes[cur]); end
            else if (r < 85) begin cur = int'($urandom_range(0, CYC - 1)); step(0, 1, codes[cur]); end
            else if (r < 92) step(0, 1, codes[cur]);
            else begin w = int'($urandom_range(0, 15)); step(0, 1, w); end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter N, default 4: Johnson code width; the legal cycle length is 2N.
REQ-002 Parameter LOCK_CNT, default 2: consecutive correct successors needed to lock.
REQ-003 Parameter ERR_LIMIT, default 3: consecutive errors while locked that force loss of lock.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  jc_in is sampled on this cycle.
REQ-007 jc_in  input  N  Johnson-coded word from the twisted-ring counter.
REQ-008 bin_out  output  $clog2(2N)  binary index of the last legal code.
REQ-009 bin_valid  output  1  one-cycle pulse when bin_out updates.
REQ-010 illegal  output  1  one-cycle pulse when a sampled word is not a legal Johnson code.
REQ-011 seq_err  output  1  one-cycle pulse when a legal code is not the expected successor.
REQ-012 locked  output  1  level, high while in LOCKED state.
REQ-013 wrap_cnt  output  8  count of completed cycles (index 2N-1 followed by 0) while locked.

Function
REQ-014 Legal cycle order (N=4): 0000,0001,0011,0111,1111,1110,1100,1000, with indices 0..7 and wrap back to 0000; each next word is the current word shifted left with bit0 = ~MSB.
REQ-015 A word is legal iff its ones form a contiguous run starting at bit0 (MSB=0) or a contiguous run ending at MSB (MSB=1), or it is all zeros.
REQ-016 Decode: MSB=0 gives index = popcount; MSB=1 gives index = 2N - popcount.
REQ-017 All outputs are registered; latency from the in_valid sample to its outputs is exactly 1 cycle.
REQ-018 Cycles with in_valid=0 change no state and produce no pulses.
REQ-019 A legal sample updates bin_out and pulses bin_valid in every state; an illegal sample holds bin_out, pulses illegal and never pulses bin_valid.
REQ-020 FSM states: HUNT, CHECK, LOCKED.
REQ-021 HUNT: a legal sample stores its index as the reference, clears the good count and moves to CHECK; an illegal sample stays in HUNT; seq_err is never pulsed.
REQ-022 CHECK: a correct successor (index+1 mod 2N) increments the good count and moves to LOCKED when it reaches LOCK_CNT; a legal wrong code pulses seq_err, re-references on that code and clears the good count; an illegal code returns to HUNT.
REQ-023 LOCKED: a correct successor clears the error count; a legal wrong code or an illegal code increments the error count; a legal wrong code pulses seq_err and re-references on the received code.
REQ-024 LOCKED: reaching ERR_LIMIT consecutive errors moves to HUNT, clears the error count and drops locked on the same output cycle.
REQ-025 A repeated identical code counts as a sequence error, not a hold.
REQ-026 wrap_cnt increments on a correct 2N-1 -> 0 transition in LOCKED only, saturates at 255, and holds its value across loss of lock.

Reset
REQ-027 rst, sampled high on a clock edge, overrides in_valid and sets state=HUNT, all counts=0, bin_out=0, wrap_cnt=0 and bin_valid=illegal=seq_err=locked=0.
REQ-028 rst asserted mid-sequence discards the reference; the first legal sample after reset is treated as a HUNT sample.

Structure
REQ-029 A shared package holds the FSM state enum and the legality and index-decode functions, parameterised on N.
REQ-030 The combinational legality/decode logic sits in one sub-module, johnson_code_decode; the FSM and counters sit in the top level.

Verification
REQ-031 Reset, then feed 0000,0001,0011 -> locked rises 1 cycle after the 0011 sample; bin_out = 0,1,2.
REQ-032 Locked, feed 1000 then 0000 -> wrap_cnt goes 0 -> 1; no seq_err.
REQ-033 Locked, inject 0101 -> illegal pulses, bin_out holds, bin_valid=0, locked stays 1.
REQ-034 Locked, feed 0111 then 1100 -> seq_err pulses and bin_out=6; continuing with 1000 gives no error.
REQ-035 Locked, feed three consecutive errors (0101,0101,1011) -> locked falls after the third; next legal 0011 enters CHECK.
REQ-036 Assert rst while locked with wrap_cnt=5 -> all outputs 0 on the next cycle; in_valid during rst is ignored.
